hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Producer side of the Control unit's NoOp_i: detects data hazards between the instruction in ID and older instructions in EX, and sequences the stall/flush bubbles.
- Sits between the IF/ID and ID/EX pipeline registers of the 5-stage RV32 core.
- Drives NoOp_o (bubble into ID/EX via Control), PCWrite_o and IFIDWrite_o (freeze front end), and IFFlush_o (squash on taken branch).
- Branches resolve in ID, so a branch that depends on an older result needs extra stall cycles. A registered countdown state machine sequences them.

Parameters:
- STALL_W, 2, width of the stall countdown counter (max count 3).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- IFID_Op_i  input  7  opcode of the instruction in ID
- IFID_RS1_i  input  5  rs1 of the instruction in ID
- IFID_RS2_i  input  5  rs2 of the instruction in ID
- IDEX_MemRead_i  input  1  instruction in EX is a load
- IDEX_RegWrite_i  input  1  instruction in EX writes a register
- IDEX_RD_i  input  5  rd of the instruction in EX
- BranchTaken_i  input  1  branch in ID resolved taken (rs1==rs2 && Branch)
- NoOp_o  output  1  insert bubble into ID/EX
- PCWrite_o  output  1  PC update enable
- IFIDWrite_o  output  1  IF/ID register write enable
- IFFlush_o  output  1  clear IF/ID to NOP

Behaviour:
- Reset: clk_i is the only clock; rst_i is synchronous and active-high.
  - When rst_i is high at a clk_i edge: state goes to RUN and cnt to 0.
  - Outputs during reset: NoOp_o=0, PCWrite_o=1, IFIDWrite_o=1, IFFlush_o=0.
  - A reset in the middle of a stall aborts it; no residual bubbles follow.
- Dependency check (combinational):
  - dep1 = IFID_RS1_i==IDEX_RD_i, and IDEX_RD_i != 0.
  - dep2 = IFID_RS2_i==IDEX_RD_i, and IDEX_RD_i != 0, and the opcode uses rs2 (R, SW, BEQ).
  - I and LW opcodes use rs1 only. x0 never creates a hazard.
  - dep = (dep1 | dep2) & (IDEX_MemRead_i | IDEX_RegWrite_i).
- Stall cost, evaluated in RUN only:
  - Non-branch in ID, load in EX with dep: 1 stall cycle.
  - BEQ in ID, ALU producer (RegWrite & !MemRead) in EX with dep: 1 stall cycle.
  - BEQ in ID, load in EX with dep: 2 stall cycles.
  - Otherwise: 0.
- States:
  - RUN:
    - If cost>0: assert stall outputs this cycle, load cnt=cost-1. Next state is STALL if cost-1>0, otherwise RUN.
    - Else if Op==BEQ and BranchTaken_i: IFFlush_o=1 for one cycle, stay in RUN.
  - STALL: assert stall outputs, decrement cnt, return to RUN when cnt reaches 0 (after its final stall cycle). Dependency inputs are ignored in this state.
- Stall outputs: NoOp_o=1, PCWrite_o=0, IFIDWrite_o=0, IFFlush_o=0.
- Simultaneous events:
  - BranchTaken_i is ignored while stalling, whether cost>0 in RUN or in STALL, because operands are not yet valid.
  - Flush occurs only on the first non-stall cycle of the branch.
  - Stall has priority over flush.
- Latency: the hazard is signalled in the same cycle it is detected. The total bubble count equals cost exactly.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs StallCnt_o[31:0] and FlushCnt_o[31:0].
  - StallCnt_o increments on every cycle NoOp_o=1; FlushCnt_o increments on every cycle IFFlush_o=1.
  - Both counters clear on rst_i and wrap modulo 2^32.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- define.v holds:
  - existing opcode constants (R, I, LW, SW, BEQ);
  - new HAZ_RUN/HAZ_STALL state encodings;
  - stall-cost constants LOAD_USE_STALL=1, ALU_BR_STALL=1, LOAD_BR_STALL=2.
- Sub-module hazard_dep_check: purely combinational. Takes the opcode, rs1/rs2 and the EX-stage fields, and produces dep and cost.
- The top level holds the FSM, the counter and the optional perf counters.

Test Plan:
- Hazard-free stream:
  - Stimulus: ADD x3,x1,x2 in ID; ADDI x5 (RegWrite=1, MemRead=0) in EX.
  - Response: all outputs stay at their reset values.
- Load-use:
  - Stimulus: LW x5 in EX; ADD x6,x5,x1 in ID.
  - Response: exactly 1 cycle with NoOp_o=1, PCWrite_o=0, IFIDWrite_o=0, then back to RUN.
  - Repeat with rd=x0: no stall.
- Load-to-branch:
  - Stimulus: LW x7 in EX; BEQ x7,x2 in ID.
  - Response: 2 consecutive stall cycles, even though EX inputs change in cycle 2.
  - Then BranchTaken_i=1 produces IFFlush_o=1 for exactly 1 cycle.
- ALU-to-branch with early taken:
  - Stimulus: ADD x4 in EX; BEQ x1,x4 in ID; BranchTaken_i=1 in the same cycle.
  - Response: 1 stall cycle with IFFlush_o=0. The next cycle gives IFFlush_o=1.
- rs2 use:
  - Stimulus: LW x9 in EX; ADDI x1,x2 in ID whose IFID_RS2_i field equals 9.
  - Response: no stall, since I-type has no rs2.
  - Same stimulus with SW in ID: 1 stall cycle.
- Reset mid-stall:
  - Stimulus: assert rst_i in cycle 1 of a 2-cycle load-to-branch stall.
  - Response: the next cycle shows the reset output values and state RUN.
  - With HAZARD_PERF_CNT_EN defined: StallCnt_o reads 0 after reset.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared opcode constants, hazard FSM state encoding and stall-cost constants
// for the ID-stage hazard/stall controller.
package hazard_stall_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [0:0] {
    HAZ_RUN   = 1'b0,
    HAZ_STALL = 1'b1
  } haz_state_e;

  localparam int unsigned LOAD_USE_STALL = 32'd1;
  localparam int unsigned ALU_BR_STALL   = 32'd1;
  localparam int unsigned LOAD_BR_STALL  = 32'd2;

  // Only R-type, stores and branches read rs2; the field is immediate bits otherwise.
  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_R, OP_SW, OP_BEQ: uses_rs2 = 1'b1;
      default:             uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_dep_check.sv
// Combinational RAW dependency check between the ID instruction and the EX
// producer, and the resulting number of stall cycles.
module hazard_dep_check
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned STALL_W = 2
) (
  input  logic [6:0]         op_i,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  input  logic               ex_mem_read_i,
  input  logic               ex_reg_write_i,
  input  logic [4:0]         ex_rd_i,
  output logic               dep_o,
  output logic [STALL_W-1:0] cost_o
);

  logic rd_nz_s;
  logic dep1_s;
  logic dep2_s;
  logic is_beq_s;

  // Dependency detection and cost selection; x0 never produces a hazard.
  always_comb begin
    rd_nz_s  = (ex_rd_i != 5'd0);
    dep1_s   = rd_nz_s & (rs1_i == ex_rd_i);
    dep2_s   = rd_nz_s & (rs2_i == ex_rd_i) & uses_rs2(op_i);
    dep_o    = (dep1_s | dep2_s) & (ex_mem_read_i | ex_reg_write_i);
    is_beq_s = (op_i == OP_BEQ);
    cost_o   = '0;
    if (dep_o) begin
      if (is_beq_s && ex_mem_read_i) begin
        cost_o = STALL_W'(LOAD_BR_STALL);
      end else if (is_beq_s && ex_reg_write_i) begin
        cost_o = STALL_W'(ALU_BR_STALL);
      end else if (!is_beq_s && ex_mem_read_i) begin
        cost_o = STALL_W'(LOAD_USE_STALL);
      end else begin
        cost_o = '0;
      end
    end else begin
      cost_o = '0;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard stall/flush sequencer between IF/ID and ID/EX of the RV32 pipeline.
// Optional macro HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned STALL_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  IFID_Op_i,
  input  logic [4:0]  IFID_RS1_i,
  input  logic [4:0]  IFID_RS2_i,
  input  logic        IDEX_MemRead_i,
  input  logic        IDEX_RegWrite_i,
  input  logic [4:0]  IDEX_RD_i,
  input  logic        BranchTaken_i,
  output logic        NoOp_o,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        IFFlush_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt_o,
  output logic [31:0] FlushCnt_o
`endif
);

  localparam logic [STALL_W-1:0] CNT_ONE = STALL_W'(1);

  haz_state_e         state_q, state_d;
  logic [STALL_W-1:0] cnt_q, cnt_d;
  logic               dep_s;
  logic [STALL_W-1:0] cost_s;
  logic               stall_s;
  logic               flush_s;

  hazard_dep_check #(
    .STALL_W (STALL_W)
  ) u_dep_check (
    .op_i           (IFID_Op_i),
    .rs1_i          (IFID_RS1_i),
    .rs2_i          (IFID_RS2_i),
    .ex_mem_read_i  (IDEX_MemRead_i),
    .ex_reg_write_i (IDEX_RegWrite_i),
    .ex_rd_i        (IDEX_RD_i),
    .dep_o          (dep_s),
    .cost_o         (cost_s)
  );

  // Next state and stall/flush decision; the first stall cycle is the detect cycle itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_s = 1'b0;
    flush_s = 1'b0;
    if (rst_i) begin
      state_d = HAZ_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        HAZ_RUN: begin
          if (dep_s && (cost_s != '0)) begin
            stall_s = 1'b1;
            cnt_d   = cost_s - CNT_ONE;
            state_d = (cnt_d != '0) ? HAZ_STALL : HAZ_RUN;
          end else if ((IFID_Op_i == OP_BEQ) && BranchTaken_i) begin
            flush_s = 1'b1;
          end else begin
            state_d = HAZ_RUN;
          end
        end
        HAZ_STALL: begin
          stall_s = 1'b1;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_d == '0) ? HAZ_RUN : HAZ_STALL;
        end
        default: begin
          state_d = HAZ_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign NoOp_o      = stall_s;
  assign PCWrite_o   = ~stall_s;
  assign IFIDWrite_o = ~stall_s;
  assign IFFlush_o   = flush_s;

  // State and countdown registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HAZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Free-running event counters, wrapping modulo 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_s};
    flush_cnt_d = flush_cnt_q + {31'd0, flush_s};
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed by
// randomized traffic, checked against a cycle-level reference model.
module tb_hazard_stall_ctrl;

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [4:0] rs1, rs2, rd;
  logic       mr, rw, taken;
  logic       noop, pcw, ifidw, flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int rem      = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .IFID_Op_i       (op),
    .IFID_RS1_i      (rs1),
    .IFID_RS2_i      (rs2),
    .IDEX_MemRead_i  (mr),
    .IDEX_RegWrite_i (rw),
    .IDEX_RD_i       (rd),
    .BranchTaken_i   (taken),
    .NoOp_o          (noop),
    .PCWrite_o       (pcw),
    .IFIDWrite_o     (ifidw),
    .IFFlush_o       (flush)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCnt_o      (stall_cnt),
    .FlushCnt_o      (flush_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Number of bubbles the ID instruction needs behind the current EX instruction.
  function automatic int model_cost();
    bit reads_rs2;
    bit hit;
    reads_rs2 = (op == T_R) || (op == T_SW) || (op == T_BEQ);
    hit = (rd != 5'd0) && ((rs1 == rd) || (reads_rs2 && (rs2 == rd))) && (mr || rw);
    if (!hit) return 0;
    if (op == T_BEQ) return mr ? 2 : 1;
    return mr ? 1 : 0;
  endfunction

  task automatic set_in(input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                        input logic m, input logic w, input logic [4:0] d, input logic t);
    op = o; rs1 = a; rs2 = b; mr = m; rw = w; rd = d; taken = t;
  endtask

  // One clock: predict, sample at negedge, advance the model.
  task automatic cycle(input string tag);
    bit e_stall;
    bit e_flush;
    int c;
    e_stall = 1'b0;
    e_flush = 1'b0;
    c = 0;
    if (rst) begin
      e_stall = 1'b0;
    end else if (rem > 0) begin
      e_stall = 1'b1;
    end else begin
      c = model_cost();
      if (c > 0) e_stall = 1'b1;
      else if ((op == T_BEQ) && taken) e_flush = 1'b1;
    end
    @(negedge clk);
    check_val({tag, ".noop"},  {31'd0, noop},  {31'd0, e_stall});
    check_val({tag, ".pcw"},   {31'd0, pcw},   {31'd0, ~e_stall});
    check_val({tag, ".ifidw"}, {31'd0, ifidw}, {31'd0, ~e_stall});
    check_val({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
`ifdef HAZARD_PERF_CNT_EN
    check_val({tag, ".stallcnt"}, stall_cnt, 32'(m_stall));
    check_val({tag, ".flushcnt"}, flush_cnt, 32'(m_flush));
`endif
    if (rst) begin
      rem = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (rem > 0) rem--;
      else if (c > 0) rem = c - 1;
      m_stall += int'(e_stall);
      m_flush += int'(e_flush);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] ops [6];
    ops[0] = T_R; ops[1] = T_I; ops[2] = T_LW; ops[3] = T_SW; ops[4] = T_BEQ; ops[5] = T_JAL;
    rst = 1'b1;
    set_in(T_R, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    cycle("reset");
    rst = 1'b0;

    set_in(T_R, 5'd1, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0);
    cycle("nohaz");
    cycle("nohaz2");

    set_in(T_R, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0);
    cycle("lduse");
    set_in(T_R, 5'd5, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0);
    cycle("lduse_after");
    set_in(T_R, 5'd0, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0);
    cycle("lduse_x0");

    set_in(T_BEQ, 5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0);
    cycle("ldbr1");
    set_in(T_BEQ, 5'd7, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
    cycle("ldbr2");
    cycle("ldbr_flush");
    set_in(T_R, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    cycle("ldbr_after");

    set_in(T_BEQ, 5'd1, 5'd4, 1'b0, 1'b1, 5'd4, 1'b1);
    cycle("alubr_stall");
    set_in(T_BEQ, 5'd1, 5'd4, 1'b0, 1'b0, 5'd0, 1'b1);
    cycle("alubr_flush");

    set_in(T_I, 5'd2, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0);
    cycle("rs2_itype");
    set_in(T_SW, 5'd2, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0);
    cycle("rs2_sw");
    set_in(T_SW, 5'd2, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0);
    cycle("rs2_after");

    set_in(T_BEQ, 5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0);
    cycle("rstmid_stall");
    rst = 1'b1;
    cycle("rstmid_rst");
    rst = 1'b0;
    set_in(T_R, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
    cycle("rstmid_after");

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(99) < 2);
      set_in(ops[$urandom_range(5)], 5'($urandom_range(3)), 5'($urandom_range(3)),
             1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(3)),
             1'($urandom_range(1)));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
